// File: rtl/hc595_tx_pkg.sv
// Shared state type and default geometry for the 74HC595 serial transmitter.
package hc595_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } tx_state_e;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/hc595_serial_tx_timer.sv
// sclk_phase_timer: free-running CLK_DIV divider producing a one-cycle phase_done tick,
// realigned whenever a new word starts so every phase of that word is exactly CLK_DIV cycles.
module sclk_phase_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic phase_done
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_r;

   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("sclk_phase_timer: CLK_DIV must be >= 1");
   end

   // Phase counter: wraps every CLK_DIV cycles, restarts at zero when a word is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (restart) begin
         cnt_r <= '0;
      end else if (cnt_r == LAST_CNT) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign phase_done = (cnt_r == LAST_CNT);

endmodule

// File: rtl/hc595_serial_tx.sv
// hc595_serial_tx: shifts handshaked line words into a 74HC595 chain and strobes RCLK once per word.
// Optional display blanking around the latch is enabled by defining HC595_TX_BLANK_EN.
module hc595_serial_tx
   import hc595_tx_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              sclk,
   output logic              sdata,
   output logic              rclk,
   output logic              oe_n,
   output logic              busy
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   tx_state_e         state_r;
   logic [DATA_W-1:0] shreg_r;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic              s_ready_r;
   logic              sclk_r;
   logic              sdata_r;
   logic              rclk_r;
   logic              busy_r;

   logic              accept_s;
   logic              phase_done_s;
   logic              latch_start_s;
   logic              latch_end_s;
   logic [DATA_W-1:0] shreg_next_s;

   function automatic logic head_bit(input logic [DATA_W-1:0] word);
      return LSB_FIRST ? word[0] : word[DATA_W-1];
   endfunction

   assign accept_s      = s_valid && s_ready_r;
   assign shreg_next_s  = LSB_FIRST ? {1'b0, shreg_r[DATA_W-1:1]} : {shreg_r[DATA_W-2:0], 1'b0};
   assign latch_start_s = (state_r == SHIFT) && phase_done_s && sclk_r && (bit_cnt_r == LAST_BIT);
   assign latch_end_s   = (state_r == LATCH) && phase_done_s;

   sclk_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .clk        (clk),
      .rst        (rst),
      .restart    (accept_s),
      .phase_done (phase_done_s)
   );

   // Transmit FSM: word capture, bit serialisation on SCLK, then the RCLK strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         shreg_r   <= '0;
         bit_cnt_r <= '0;
         s_ready_r <= 1'b0;
         sclk_r    <= 1'b0;
         sdata_r   <= 1'b0;
         rclk_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r   <= SHIFT;
                  shreg_r   <= s_data;
                  bit_cnt_r <= '0;
                  sdata_r   <= head_bit(s_data);
                  sclk_r    <= 1'b0;
                  s_ready_r <= 1'b0;
                  busy_r    <= 1'b1;
               end else begin
                  s_ready_r <= 1'b1;
               end
            end
            SHIFT: begin
               if (phase_done_s) begin
                  if (!sclk_r) begin
                     sclk_r <= 1'b1;
                  end else if (bit_cnt_r == LAST_BIT) begin
                     // SER returns low while the chain is latched.
                     sclk_r  <= 1'b0;
                     sdata_r <= 1'b0;
                     rclk_r  <= 1'b1;
                     state_r <= LATCH;
                  end else begin
                     sclk_r    <= 1'b0;
                     bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                     shreg_r   <= shreg_next_s;
                     sdata_r   <= head_bit(shreg_next_s);
                  end
               end
            end
            LATCH: begin
               if (phase_done_s) begin
                  rclk_r    <= 1'b0;
                  busy_r    <= 1'b0;
                  s_ready_r <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               shreg_r   <= '0;
               bit_cnt_r <= '0;
               s_ready_r <= 1'b0;
               sclk_r    <= 1'b0;
               sdata_r   <= 1'b0;
               rclk_r    <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

`ifdef HC595_TX_BLANK_EN
   localparam int TAIL_W = $clog2(CLK_DIV + 1);

   logic [TAIL_W-1:0] tail_r;
   logic              oe_n_r;

   // Blanking: /OE high for the whole latch plus CLK_DIV cycles after it, independent of the next word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tail_r <= '0;
         oe_n_r <= 1'b0;
      end else if (latch_start_s) begin
         oe_n_r <= 1'b1;
      end else if (latch_end_s) begin
         tail_r <= TAIL_W'(CLK_DIV);
      end else if (tail_r != '0) begin
         tail_r <= tail_r - TAIL_W'(1);
         if (tail_r == TAIL_W'(1)) begin
            oe_n_r <= 1'b0;
         end
      end
   end

   assign oe_n = oe_n_r;
`else
   assign oe_n = 1'b0;
`endif

   assign s_ready = s_ready_r;
   assign sclk    = sclk_r;
   assign sdata   = sdata_r;
   assign rclk    = rclk_r;
   assign busy    = busy_r;

endmodule

// File: tb/tb_hc595_serial_tx.sv
// Scoreboard bench for hc595_serial_tx: an LSB-first and an MSB-first instance, both CLK_DIV=2.
module tb_hc595_serial_tx;

   localparam int DW       = 16;
   localparam int CD       = 2;
   localparam int PERIOD   = 2*CD*DW + CD + 1;
   localparam int RCLK_LAT = 2*CD*DW + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic          a_ready, a_sclk, a_sdata, a_rclk, a_oe_n, a_busy;
   logic          b_ready, b_sclk, b_sdata, b_rclk, b_oe_n, b_busy;

   always #5 clk = ~clk;

   hc595_serial_tx #(.DATA_W(DW), .CLK_DIV(CD), .LSB_FIRST(1'b1)) u_dut (
      .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
      .sclk(a_sclk), .sdata(a_sdata), .rclk(a_rclk), .oe_n(a_oe_n), .busy(a_busy));

   hc595_serial_tx #(.DATA_W(DW), .CLK_DIV(CD), .LSB_FIRST(1'b0)) u_dut_msb (
      .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
      .sclk(b_sclk), .sdata(b_sdata), .rclk(b_rclk), .oe_n(b_oe_n), .busy(b_busy));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: words expected to appear at the 595 outputs, in order.
   logic [DW-1:0] exp_a[$];
   logic [DW-1:0] exp_b[$];
   int            hs_a_cyc = 0;
   int            hs_b_cyc = 0;

   // Monitor state
   logic          a_bits[$];
   logic          b_bits[$];
   logic          a_prev_sclk = 1'b0, a_prev_rclk = 1'b0, a_prev_oe = 1'b0;
   logic          b_prev_sclk = 1'b0, b_prev_rclk = 1'b0;
   int            a_rises = 0, a_rclks = 0, a_rclk_start = 0, a_oe_start = 0;
   int            a_idle_bad = 0, a_oe_bad = 0, b_rclks = 0;
   logic [DW-1:0] a_word, b_word;

   always @(negedge clk) begin
      if (rst) begin
         a_bits.delete();
         a_prev_sclk = 1'b0;
         a_prev_rclk = 1'b0;
         a_prev_oe   = 1'b0;
      end else begin
         if (a_sclk && !a_prev_sclk) begin
            a_bits.push_back(a_sdata);
            a_rises++;
         end
         if (a_rclk && !a_prev_rclk) begin
            a_rclks++;
            a_rclk_start = cyc;
            check("a_rclk_latency", cyc - hs_a_cyc, RCLK_LAT);
            check("a_bits_per_word", a_bits.size(), DW);
            if (exp_a.size() == 0) begin
               check("a_rclk_without_word", exp_a.size(), 1);
            end else begin
               a_word = '0;
               for (int i = 0; i < a_bits.size() && i < DW; i++) a_word[i] = a_bits[i];
               check("a_word_lsb_first", a_word, exp_a.pop_front());
            end
            a_bits.delete();
         end
         if (!a_rclk && a_prev_rclk) check("a_rclk_width", cyc - a_rclk_start, CD);
`ifdef HC595_TX_BLANK_EN
         if (a_oe_n && !a_prev_oe) begin
            a_oe_start = cyc;
            check("a_oe_starts_with_rclk", {a_rclk, a_prev_rclk}, 2'b10);
         end
         if (!a_oe_n && a_prev_oe) check("a_oe_blank_len", cyc - a_oe_start, 2*CD);
`else
         if (a_oe_n !== 1'b0) a_oe_bad++;
`endif
         if (!a_busy && (a_sclk || a_rclk || a_sdata)) a_idle_bad++;
         if (a_busy && a_ready) a_idle_bad++;
         a_prev_sclk = a_sclk;
         a_prev_rclk = a_rclk;
         a_prev_oe   = a_oe_n;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         b_bits.delete();
         b_prev_sclk = 1'b0;
         b_prev_rclk = 1'b0;
      end else begin
         if (b_sclk && !b_prev_sclk) b_bits.push_back(b_sdata);
         if (b_rclk && !b_prev_rclk) begin
            b_rclks++;
            check("b_bits_per_word", b_bits.size(), DW);
            check("b_rclk_latency", cyc - hs_b_cyc, RCLK_LAT);
            if (exp_b.size() == 0) begin
               check("b_rclk_without_word", exp_b.size(), 1);
            end else begin
               b_word = '0;
               for (int i = 0; i < b_bits.size(); i++) b_word = {b_word[DW-2:0], b_bits[i]};
               check("b_word_msb_first", b_word, exp_b.pop_front());
            end
            b_bits.delete();
         end
         b_prev_sclk = b_sclk;
         b_prev_rclk = b_rclk;
      end
   end

   // Drivers are entered at a negedge and return at a negedge.
   task automatic send_a(input logic [DW-1:0] w, input bit hold);
      int waited = 0;
      a_data  = w;
      a_valid = 1'b1;
      while (!a_ready && waited < 4*PERIOD) begin
         @(negedge clk);
         waited++;
      end
      check("a_handshake_in_time", a_ready, 1'b1);
      if (a_ready) begin
         exp_a.push_back(w);
         hs_a_cyc = cyc;
         @(negedge clk);
      end
      if (!hold) a_valid = 1'b0;
   endtask

   task automatic send_b(input logic [DW-1:0] w);
      int waited = 0;
      b_data  = w;
      b_valid = 1'b1;
      while (!b_ready && waited < 4*PERIOD) begin
         @(negedge clk);
         waited++;
      end
      check("b_handshake_in_time", b_ready, 1'b1);
      if (b_ready) begin
         exp_b.push_back(w);
         hs_b_cyc = cyc;
         @(negedge clk);
      end
      b_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0 || a_busy || b_busy) && k < 6*PERIOD) begin
         @(negedge clk);
         k++;
      end
      check(name, exp_a.size() + exp_b.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, r0, base;
      logic [DW-1:0] w;
      bit hold;

      repeat (3) @(negedge clk);
      check("a_reset_outputs", {a_ready, a_sclk, a_sdata, a_rclk, a_oe_n, a_busy}, 6'b0);
      check("b_reset_outputs", {b_ready, b_sclk, b_sdata, b_rclk, b_oe_n, b_busy}, 6'b0);
      #2 rst = 1'b0;
      @(negedge clk);
      check("a_ready_after_reset", a_ready, 1'b1);
      check("b_ready_after_reset", b_ready, 1'b1);

      // Single word, LSB first
      w = 16'hA5C3;
      send_a(w, 1'b0);
      check("a_busy_in_shift", {a_busy, a_ready, a_sclk}, 3'b100);
      check("a_first_bit_on_entry", a_sdata, w[0]);
      t0 = 0;
      while (!a_ready && t0 < 4*PERIOD) begin
         @(negedge clk);
         t0++;
      end
      check("a_word_period", cyc - hs_a_cyc, PERIOD);

      // Idle with nothing offered
      repeat (20) @(negedge clk);
      check("a_idle_quiet", {a_sclk, a_rclk, a_sdata}, 3'b000);

      // MSB-first instance
      send_b(16'h8001);
      drain("b_8001_drained");
      send_b(16'($urandom));
      drain("b_random_drained");

      // Back-to-back with s_valid held high
      r0   = a_rclks;
      base = a_rises;
      send_a(16'($urandom), 1'b1);
      t0 = hs_a_cyc;
      send_a(16'($urandom), 1'b1);
      check("b2b_gap_1", hs_a_cyc - t0, PERIOD);
      t0 = hs_a_cyc;
      send_a(16'($urandom), 1'b0);
      check("b2b_gap_2", hs_a_cyc - t0, PERIOD);
      drain("b2b_drained");
      check("b2b_rclk_count", a_rclks - r0, 3);
      check("b2b_sclk_rises", a_rises - base, 3*DW);

      // Reset in the middle of a word
      r0   = a_rclks;
      base = a_rises;
      send_a(16'hFFFF, 1'b0);
      t0 = 0;
      while (a_rises < base + 7 && t0 < 2*PERIOD) begin
         @(negedge clk);
         t0++;
      end
      check("abort_reached_7_rises", a_rises - base, 7);
      #2 rst = 1'b1;
      #1 check("a_async_reset_outputs", {a_ready, a_sclk, a_sdata, a_rclk, a_oe_n, a_busy}, 6'b0);
      exp_a.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("a_ready_after_abort", a_ready, 1'b1);
      send_a(16'h0000, 1'b0);
      drain("abort_next_drained");
      check("abort_single_rclk", a_rclks - r0, 1);

      // Randomised traffic with random gaps and held s_valid
      for (int n = 0; n < 12; n++) begin
         hold = (n != 11) && ($urandom_range(0, 1) == 1);
         send_a(16'($urandom), hold);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain("random_drained");

      check("a_idle_and_ready_rules", a_idle_bad, 0);
`ifndef HC595_TX_BLANK_EN
      check("a_oe_n_always_low", a_oe_bad, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
